// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, test-pattern encoding and colour-bar mask helper.
package vga_pkg;
   localparam logic [9:0] H_ACTIVE = 10'd640;
   localparam logic [9:0] V_ACTIVE = 10'd480;
   localparam logic [9:0] H_TOTAL  = 10'd800;
   localparam logic [9:0] V_TOTAL  = 10'd525;
   localparam logic [9:0] BAR_PX   = 10'd80;
   typedef enum logic [1:0] {PAT_SOLID, PAT_BARS, PAT_CHECKER, PAT_MOVEBAR} pattern_t;
   // Per-channel on/off mask; the pixel stage expands each bit to full scale.
   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } rgb_t;
   // Bar order white, yellow, cyan, green, magenta, red, blue, black.
   function automatic rgb_t bar_mask(input logic [2:0] idx);
      return '{r: ~idx[1], g: ~idx[2], b: ~idx[0]};
   endfunction
   function automatic logic in_active(input logic [9:0] h, input logic [9:0] v);
      return h < H_TOTAL && v < V_TOTAL && h < H_ACTIVE && v < V_ACTIVE;
   endfunction
endpackage

// File: rtl/vga_pipe_delay.sv
// vga_pipe_delay: DEPTH-stage shift register whose stages all load RST_VAL on async reset.
module vga_pipe_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             Clock25,
   input  logic             Reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [DEPTH-1:0][WIDTH-1:0] sr_q;
   always_ff @(posedge Clock25 or posedge Reset)
      if (Reset) sr_q <= {DEPTH{RST_VAL}};
      else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
   assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: 2-cycle 640x480 test-pattern pixel stage with sync alignment.
// Define VGA_BORDER_EN to force the outermost active pixels to white.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int COLOR_BITS   = 4,
   parameter int BAR_WIDTH    = 16,
   parameter int BAR_STEP     = 4,
   parameter int CHECKER_LOG2 = 5
) (
   input  logic                    Clock25,
   input  logic                    Reset,
   input  logic                    HorizontalSync,
   input  logic                    VerticalSync,
   input  logic [9:0]              HorizontalCounter,
   input  logic [9:0]              VerticalCounter,
   input  logic                    PatternLoad,
   input  logic [1:0]              PatternSelect,
   input  logic [3*COLOR_BITS-1:0] SolidColor,
   output logic [COLOR_BITS-1:0]   Red,
   output logic [COLOR_BITS-1:0]   Green,
   output logic [COLOR_BITS-1:0]   Blue,
   output logic                    HsyncOut,
   output logic                    VsyncOut,
   output logic [7:0]              FrameCount
);
   logic                    act1;
   logic [9:0]              h1, v1;
   logic                    fs;
   pattern_t                pend_pat_q, act_pat_q, pat;
   logic [3*COLOR_BITS-1:0] pend_col_q, act_col_q, col;
   logic [9:0]              bar_q, bar_d;
   logic [10:0]             bar_sum;
   logic [7:0]              fc_q;
   logic [2:0]              idx;
   rgb_t                    mask;
   logic [3*COLOR_BITS-1:0] rgb_d, rgb_q;

   vga_pipe_delay #(.WIDTH(21), .DEPTH(1)) u_stage1 (
      .Clock25 (Clock25),
      .Reset   (Reset),
      .d_i     ({in_active(HorizontalCounter, VerticalCounter), HorizontalCounter, VerticalCounter}),
      .q_o     ({act1, h1, v1})
   );

   vga_pipe_delay #(.WIDTH(2), .DEPTH(2), .RST_VAL(2'b11)) u_sync (
      .Clock25 (Clock25),
      .Reset   (Reset),
      .d_i     ({HorizontalSync, VerticalSync}),
      .q_o     ({HsyncOut, VsyncOut})
   );

   // Qualified with act1 so the cleared stage-1 counters after reset are not a frame start.
   assign fs = act1 && h1 == 10'd0 && v1 == 10'd0;
   // Pixel (0,0) already belongs to the new frame, so it sees the values being committed.
   assign pat = fs ? pend_pat_q : act_pat_q;
   assign col = fs ? pend_col_q : act_col_q;
   assign bar_sum = {1'b0, bar_q} + 11'(BAR_STEP);
   assign bar_d = (fs && act_pat_q == PAT_MOVEBAR)
                ? (bar_sum >= 11'(H_ACTIVE) ? 10'(bar_sum - 11'(H_ACTIVE)) : bar_sum[9:0])
                : bar_q;

   always_comb begin
      idx = '0;
      for (int k = 1; k < 8; k++) if (h1 >= 10'(k) * BAR_PX) idx = 3'(k);
      mask = pat == PAT_BARS    ? bar_mask(idx)
           : pat == PAT_CHECKER ? rgb_t'({3{h1[CHECKER_LOG2] ^ v1[CHECKER_LOG2]}})
           : rgb_t'({3{h1 >= bar_d && {1'b0, h1} < {1'b0, bar_d} + 11'(BAR_WIDTH)}});
      rgb_d = pat == PAT_SOLID ? col
            : {{COLOR_BITS{mask.r}}, {COLOR_BITS{mask.g}}, {COLOR_BITS{mask.b}}};
`ifdef VGA_BORDER_EN
      if (h1 == 10'd0 || h1 == H_ACTIVE - 10'd1 || v1 == 10'd0 || v1 == V_ACTIVE - 10'd1) rgb_d = '1;
`endif
      if (!act1) rgb_d = '0;
   end

   always_ff @(posedge Clock25 or posedge Reset)
      if (Reset) begin
         pend_pat_q <= PAT_SOLID;
         act_pat_q  <= PAT_SOLID;
         pend_col_q <= '0;
         act_col_q  <= '0;
         bar_q      <= '0;
         fc_q       <= '0;
         rgb_q      <= '0;
      end else begin
         if (PatternLoad) begin
            pend_pat_q <= pattern_t'(PatternSelect);
            pend_col_q <= SolidColor;
         end
         if (fs) begin
            act_pat_q <= pend_pat_q;
            act_col_q <= pend_col_q;
            fc_q      <= fc_q + 8'd1;
         end
         bar_q <= bar_d;
         rgb_q <= rgb_d;
      end

   assign {Red, Green, Blue} = rgb_q;
   assign FrameCount = fc_q;
endmodule
